// File: rtl/grey_code_rx_pkg.sv
// Shared types and Gray-code helpers for the grey_code_rx receiver.
// f_grey6 is the generator-side encoder, kept here so both ends agree on the sequence.
package grey_code_rx_pkg;

  localparam int GREY_W = 6;

  typedef enum logic {
    ACQUIRE = 1'b0,
    TRACK   = 1'b1
  } state_e;

  function automatic logic [GREY_W-1:0] f_grey6(input logic [GREY_W-1:0] b);
    return b ^ (b >> 1);
  endfunction

  function automatic logic [GREY_W-1:0] f_grey2bin6(input logic [GREY_W-1:0] g);
    logic [GREY_W-1:0] b;
    b[GREY_W-1] = g[GREY_W-1];
    for (int i = GREY_W - 2; i >= 0; i--) begin
      b[i] = b[i+1] ^ g[i];
    end
    return b;
  endfunction

  function automatic logic [2:0] f_popcount6(input logic [GREY_W-1:0] v);
    logic [2:0] n;
    n = '0;
    for (int i = 0; i < GREY_W; i++) begin
      n = n + {2'b00, v[i]};
    end
    return n;
  endfunction

endpackage

// File: rtl/grey_code_rx_if.sv
// Link-side bundle of the Gray-code receiver: incoming code, error clear and status outputs.
// master = whoever drives the code and reads status, slave = the receiver.
interface grey_code_rx_if #(
  parameter int COUNT_W = 16,
  parameter int ERR_W   = 8
);
  import grey_code_rx_pkg::*;

  logic [GREY_W-1:0]  i_grey_code;
  logic               i_err_clr;
  logic [GREY_W-1:0]  o_bin;
  logic               o_locked;
  logic               o_step;
  logic [COUNT_W-1:0] o_step_count;
  logic               o_err;
  logic               o_err_sticky;
  logic [ERR_W-1:0]   o_err_count;

  modport master (
    output i_grey_code, i_err_clr,
    input  o_bin, o_locked, o_step, o_step_count, o_err, o_err_sticky, o_err_count
  );

  modport slave (
    input  i_grey_code, i_err_clr,
    output o_bin, o_locked, o_step, o_step_count, o_err, o_err_sticky, o_err_count
  );
endinterface

// File: rtl/grey_code_rx_sync.sv
// grey_sync: plain STAGES-deep flop chain for bringing a bus into the i_clk domain.
// Only safe for Gray-coded (single-bit-change) buses; no logic between stages.
module grey_sync #(
  parameter int W      = 6,
  parameter int STAGES = 2
) (
  input  logic         i_clk,
  input  logic         i_reset,
  input  logic [W-1:0] i_d,
  output logic [W-1:0] o_q
);

  logic [W-1:0] sync_q [STAGES];
  logic [W-1:0] sync_d [STAGES];

  always_comb begin
    sync_d[0] = i_d;
    for (int k = 1; k < STAGES; k++) begin
      sync_d[k] = sync_q[k-1];
    end
  end

  always_ff @(posedge i_clk) begin
    for (int k = 0; k < STAGES; k++) begin
      if (i_reset) sync_q[k] <= '0;
      else         sync_q[k] <= sync_d[k];
    end
  end

  assign o_q = sync_q[STAGES-1];

endmodule

// File: rtl/grey_code_rx.sv
// Gray-code link receiver: synchronise, lock after a stable run, then count +1 steps
// and flag any other transition, dropping back to ACQUIRE to re-lock.
module grey_code_rx #(
  parameter int SYNC_STAGES   = 2,
  parameter int STABLE_CYCLES = 4,
  parameter int COUNT_W       = 16,
  parameter int ERR_W         = 8
) (
  input  logic           i_clk,
  input  logic           i_reset,
  grey_code_rx_if.slave  bus
);
  import grey_code_rx_pkg::*;

  localparam logic [ERR_W-1:0] ERR_MAX = '1;

  logic [GREY_W-1:0]  s_grey, s_bin, diff;
  logic               fwd_step;
  state_e             state_q, state_d;
  logic [GREY_W-1:0]  p_grey_q, p_grey_d, bin_q, bin_d, prev_q, prev_d;
  logic [3:0]         cnt_q, cnt_d;
  logic [2:0]         warm_q, warm_d;
  logic               locked_q, locked_d, step_q, step_d, err_q, err_d;
  logic               sticky_q, sticky_d;
  logic [COUNT_W-1:0] step_count_q, step_count_d;
  logic [ERR_W-1:0]   err_count_q, err_count_d;

  grey_sync #(.W(GREY_W), .STAGES(SYNC_STAGES)) u_sync (
    .i_clk   (i_clk),
    .i_reset (i_reset),
    .i_d     (bus.i_grey_code),
    .o_q     (s_grey)
  );

  assign s_bin    = f_grey2bin6(s_grey);
  assign diff     = s_grey ^ p_grey_q;
  assign fwd_step = (f_popcount6(diff) == 3'd1) && (s_bin == 6'(bin_q + 6'd1));

  always_comb begin
    state_d      = state_q;
    p_grey_d     = p_grey_q;
    bin_d        = bin_q;
    prev_d       = s_grey;
    cnt_d        = cnt_q;
    warm_d       = warm_q;
    locked_d     = locked_q;
    step_d       = 1'b0;
    err_d        = 1'b0;
    step_count_d = step_count_q;

    case (state_q)
      ACQUIRE: begin
        // Cleared synchroniser flops are not real samples: let the chain fill first.
        if (warm_q != 3'd0) begin
          warm_d = warm_q - 3'd1;
        end else begin
          cnt_d = (s_grey != prev_q) ? 4'd1 : cnt_q + 4'd1;
          if (cnt_d == 4'(STABLE_CYCLES)) begin
            state_d  = TRACK;
            p_grey_d = s_grey;
            bin_d    = s_bin;
            locked_d = 1'b1;
          end
        end
      end
      TRACK: begin
        if (diff != '0) begin
          if (fwd_step) begin
            p_grey_d     = s_grey;
            bin_d        = s_bin;
            step_d       = 1'b1;
            step_count_d = step_count_q + COUNT_W'(1);
          end else begin
            err_d    = 1'b1;
            state_d  = ACQUIRE;
            locked_d = 1'b0;
            cnt_d    = 4'd0;
          end
        end
      end
      default: state_d = ACQUIRE;
    endcase

    // Clear takes effect before a same-cycle error is recorded.
    sticky_d    = (sticky_q & ~bus.i_err_clr) | err_d;
    err_count_d = bus.i_err_clr ? '0 : err_count_q;
    if (err_d && err_count_d != ERR_MAX) err_count_d = err_count_d + ERR_W'(1);
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state_q      <= ACQUIRE;
      p_grey_q     <= '0;
      bin_q        <= '0;
      prev_q       <= '0;
      cnt_q        <= '0;
      warm_q       <= 3'(SYNC_STAGES);
      locked_q     <= 1'b0;
      step_q       <= 1'b0;
      err_q        <= 1'b0;
      sticky_q     <= 1'b0;
      step_count_q <= '0;
      err_count_q  <= '0;
    end else begin
      state_q      <= state_d;
      p_grey_q     <= p_grey_d;
      bin_q        <= bin_d;
      prev_q       <= prev_d;
      cnt_q        <= cnt_d;
      warm_q       <= warm_d;
      locked_q     <= locked_d;
      step_q       <= step_d;
      err_q        <= err_d;
      sticky_q     <= sticky_d;
      step_count_q <= step_count_d;
      err_count_q  <= err_count_d;
    end
  end

  assign bus.o_bin        = bin_q;
  assign bus.o_locked     = locked_q;
  assign bus.o_step       = step_q;
  assign bus.o_step_count = step_count_q;
  assign bus.o_err        = err_q;
  assign bus.o_err_sticky = sticky_q;
  assign bus.o_err_count  = err_count_q;

endmodule

// File: tb/tb_grey_code_rx.sv
// Self-checking bench for grey_code_rx: directed latency/boundary steps plus a random
// walk checked against a transaction-level model of the link (value, lock, counts).
module tb_grey_code_rx;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  grey_code_rx_if #(.COUNT_W(16), .ERR_W(8)) bus ();
  grey_code_rx_if #(.COUNT_W(16), .ERR_W(2)) bus2 ();

  assign bus2.i_grey_code = bus.i_grey_code;
  assign bus2.i_err_clr   = bus.i_err_clr;

  grey_code_rx #(.SYNC_STAGES(2), .STABLE_CYCLES(4), .COUNT_W(16), .ERR_W(8)) dut (
    .i_clk(clk), .i_reset(rst), .bus(bus)
  );
  grey_code_rx #(.SYNC_STAGES(2), .STABLE_CYCLES(4), .COUNT_W(16), .ERR_W(2)) dut2 (
    .i_clk(clk), .i_reset(rst), .bus(bus2)
  );

  int n_assert = 0;
  int n_fail   = 0;
  int n_step   = 0;
  int n_err    = 0;

  // Reference model: last accepted value, legal step count, errors since last clear.
  int m_last, m_count, m_errs, m_steps_total, m_errs_total;
  bit m_sticky;

  always @(negedge clk) begin
    if (bus.o_step) n_step++;
    if (bus.o_err)  n_err++;
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  function automatic logic [5:0] to_grey(input int b);
    logic [5:0] v;
    v = b[5:0];
    return v ^ (v >> 1);
  endfunction

  task automatic chk(input string tag, input int obs, input int exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic check_all(input string tag);
    @(negedge clk);
    #1;
    chk({tag, "/bin"},        int'(bus.o_bin),          m_last);
    chk({tag, "/locked"},     int'(bus.o_locked),       1);
    chk({tag, "/step_count"}, int'(bus.o_step_count),   m_count % 65536);
    chk({tag, "/err_count"},  int'(bus.o_err_count),    (m_errs > 255) ? 255 : m_errs);
    chk({tag, "/err_count2"}, int'(bus2.o_err_count),   (m_errs > 3) ? 3 : m_errs);
    chk({tag, "/sticky"},     int'(bus.o_err_sticky),   int'(m_sticky));
    chk({tag, "/step_pulses"}, n_step, m_steps_total);
    chk({tag, "/err_pulses"},  n_err,  m_errs_total);
  endtask

  // Drive binary value v (as Gray) for hold cycles; illegal codes need hold >= 7 to re-lock.
  task automatic apply(input string tag, input int v, input int hold, input bit clr_first);
    bus.i_grey_code = to_grey(v);
    bus.i_err_clr   = clr_first;
    if (clr_first) begin
      m_errs   = 0;
      m_sticky = 1'b0;
    end
    tick(1);
    bus.i_err_clr = 1'b0;
    tick(hold - 1);
    if (v != m_last) begin
      if (v == (m_last + 1) % 64) begin
        m_count++;
        m_steps_total++;
      end else begin
        m_errs++;
        m_errs_total++;
        m_sticky = 1'b1;
      end
      m_last = v;
    end
    check_all(tag);
  endtask

  task automatic reset_check(input string tag);
    rst = 1'b1;
    tick(1);
    chk({tag, "/bin"},        int'(bus.o_bin),        0);
    chk({tag, "/locked"},     int'(bus.o_locked),     0);
    chk({tag, "/step"},       int'(bus.o_step),       0);
    chk({tag, "/err"},        int'(bus.o_err),        0);
    chk({tag, "/sticky"},     int'(bus.o_err_sticky), 0);
    chk({tag, "/step_count"}, int'(bus.o_step_count), 0);
    chk({tag, "/err_count"},  int'(bus.o_err_count),  0);
    rst = 1'b0;
    m_last = 0; m_count = 0; m_errs = 0; m_sticky = 1'b0;
  endtask

  task automatic lock_seq(input string tag);
    for (int k = 1; k <= 6; k++) begin
      tick(1);
      chk({tag, "/locked_cyc"}, int'(bus.o_locked), int'(k == 6));
      chk({tag, "/no_step"},    int'(bus.o_step),   0);
      chk({tag, "/no_err"},     int'(bus.o_err),    0);
    end
    check_all(tag);
  endtask

  initial begin
    int v;
    int r;
    m_steps_total = 0;
    m_errs_total  = 0;
    bus.i_grey_code = '0;
    bus.i_err_clr   = 1'b0;
    tick(2);

    // Power-up reset and first lock on 000000.
    reset_check("reset");
    lock_seq("lock");

    // 70 legal increments, wrapping 63 -> 0.
    for (int i = 1; i <= 70; i++) apply("wrap", i % 64, 3, 1'b0);
    chk("wrap/total_steps", int'(bus.o_step_count), 70);
    chk("wrap/no_err",      n_err, 0);

    // Reset while tracking with a non-zero step count.
    bus.i_grey_code = to_grey(0);
    reset_check("mid_reset");
    lock_seq("relock");

    // Jump 1 -> 4: error three edges after the change, value held, re-lock on 4.
    apply("pre_jump", 1, 3, 1'b0);
    bus.i_grey_code = to_grey(4);
    for (int k = 1; k <= 7; k++) begin
      tick(1);
      chk("jump/err_pulse", int'(bus.o_err),    int'(k == 3));
      chk("jump/locked",    int'(bus.o_locked), int'(k < 3 || k == 7));
      chk("jump/bin",       int'(bus.o_bin),    (k == 7) ? 4 : 1);
    end
    tick(1);
    m_errs++; m_errs_total++; m_sticky = 1'b1; m_last = 4;
    check_all("jump");

    // Backward step 5 -> 4 after a clear.
    apply("pre_back", 5, 3, 1'b0);
    bus.i_err_clr = 1'b1;
    tick(1);
    bus.i_err_clr = 1'b0;
    m_errs = 0; m_sticky = 1'b0;
    check_all("clear");
    apply("backward", 4, 8, 1'b0);

    // Build err_count to 3, then clear in the same edge as a new error.
    apply("err2", 20, 8, 1'b0);
    apply("err3", 40, 8, 1'b0);
    bus.i_grey_code = to_grey(10);
    tick(2);
    bus.i_err_clr = 1'b1;
    tick(1);
    bus.i_err_clr = 1'b0;
    chk("collide/err_pulse", int'(bus.o_err),        1);
    chk("collide/err_count", int'(bus.o_err_count),  1);
    chk("collide/sticky",    int'(bus.o_err_sticky), 1);
    tick(5);
    m_errs = 1; m_errs_total++; m_sticky = 1'b1; m_last = 10;
    check_all("collide");

    // Five more errors: 2-bit counter must saturate at 3.
    apply("sat1", 30, 8, 1'b0);
    apply("sat2", 50, 8, 1'b0);
    apply("sat3", 49, 8, 1'b0);
    apply("sat4", 0, 8, 1'b0);
    apply("sat5", 33, 8, 1'b0);

    // Random walk: mostly legal steps, some backward steps and jumps, occasional clears.
    for (int i = 0; i < 80; i++) begin
      r = int'($urandom_range(0, 9));
      if (r < 7) begin
        apply("rnd_step", (m_last + 1) % 64, int'($urandom_range(3, 5)),
              $urandom_range(0, 7) == 0);
      end else if (r == 7) begin
        apply("rnd_back", (m_last + 63) % 64, 8, 1'b0);
      end else begin
        v = (m_last + 2 + int'($urandom_range(0, 61))) % 64;
        apply("rnd_jump", v, 8, 1'b0);
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/grey_code_rx.md
Name: grey_code_rx

Overview:
Receive end of the 6-bit Gray-code increment link driven by the grey_code generator.
- Synchronises the incoming code into the local i_clk domain and decodes it to binary.
- Counts legal single increments and flags illegal transitions (multi-bit jumps, backward steps).
- Re-acquires lock automatically after an illegal transition.

Parameters:
SYNC_STAGES, 2, number of synchroniser flops on i_grey_code (legal range 2..4)
STABLE_CYCLES, 4, consecutive identical synchronised samples required to lock (legal range 1..15)
COUNT_W, 16, width of the increment counter o_step_count (wraps modulo 2^COUNT_W)
ERR_W, 8, width of the saturating error counter o_err_count

Ports:
i_clk  in  1  system clock
i_reset  in  1  synchronous, active-high reset
i_grey_code  in  6  Gray code from the transmitter; may be asynchronous to i_clk
i_err_clr  in  1  one-cycle pulse; clears o_err_sticky and o_err_count
o_bin  out  6  decoded binary value of the last accepted code
o_locked  out  1  high while in TRACK
o_step  out  1  one-cycle pulse per legal +1 step
o_step_count  out  COUNT_W  total legal steps since reset
o_err  out  1  one-cycle pulse per illegal transition
o_err_sticky  out  1  set by any o_err; cleared by i_err_clr or reset
o_err_count  out  ERR_W  number of illegal transitions, saturates at all-ones

Behaviour:
- Reset: i_reset high at a clock edge produces the following register values. These apply regardless of state or mid-operation activity.
  - Synchroniser flops cleared to 0; state = ACQUIRE.
  - Outputs: o_bin=0, o_locked=0, o_step=0, o_err=0, o_err_sticky=0, o_step_count=0, o_err_count=0.
- Synchroniser: SYNC_STAGES flops in series produce s_grey. No logic is placed between the synchroniser stages.
- Decode (combinational on s_grey): bin[5]=g[5]; bin[i]=bin[i+1]^g[i]. This is standard reflected Gray, identical to the sequence produced by f_grey6.
- Internal p_grey holds the last accepted code; o_bin is the decode of p_grey.
- State ACQUIRE:
  - Stability counter resets to 1 whenever s_grey differs from its previous-cycle value, and increments otherwise.
  - When the counter reaches STABLE_CYCLES: p_grey <= s_grey, then go to TRACK.
  - No o_step or o_err is produced in ACQUIRE.
- State TRACK, evaluated every cycle on d = s_grey ^ p_grey:
  - d==0: no action.
  - popcount(d)==1 and bin(s_grey)==bin(p_grey)+1 mod 64:
    - p_grey <= s_grey; o_step pulses; o_step_count increments.
    - 63->0 (grey 100000 -> 000000) is a legal step.
  - popcount(d)==1 and bin(s_grey)==bin(p_grey)-1 mod 64 (backward step):
    - o_err pulses; go to ACQUIRE.
  - popcount(d)>=2 (jump):
    - o_err pulses; go to ACQUIRE.
  - On every error exit: p_grey and o_bin keep their last legal value.
- o_locked = (state==TRACK) as a registered output.
- Error counters:
  - An error sets o_err_sticky.
  - o_err_count increments, holding at 2^ERR_W-1.
  - An error in the same cycle as i_err_clr: the clear applies first, then the error is recorded, giving o_err_sticky=1 and o_err_count=1.
- Latency:
  - An input change stable before edge N reaches s_grey at edge N+SYNC_STAGES-1.
  - o_bin, o_step and o_err update one edge later, i.e. SYNC_STAGES+1 cycles total.
- Step pacing: at most one step is accepted per cycle. The transmitter must hold each code for at least 2 i_clk periods; faster increments are reported as jumps.

Decomposition:
- Shared package: state enum {ACQUIRE, TRACK}; constant GREY_W=6; functions f_grey2bin6 and f_popcount6.
  - f_grey2bin6 sits beside the existing f_grey6 in common.svh.
- Natural sub-module: grey_sync, a parameterised SYNC_STAGES-deep flop synchroniser. It is reusable by other crossing paths.

Test Plan:
- Lock after reset: reset, hold input 000000 for 10 cycles, SYNC_STAGES=2, STABLE_CYCLES=4 -> o_locked rises on cycle 6 after reset release; o_bin=0; no o_step, no o_err.
- Full cycle with wrap: drive 70 legal increments, each code held 3 cycles -> 70 o_step pulses; o_step_count=70; o_bin walks 0..63 then 0..6; o_err never asserted.
- Jump: locked at grey 000001 (bin 1), drive 000110 (bin 4) -> one o_err pulse 3 cycles later; o_locked=0; o_bin stays 1; after 4 stable cycles o_locked=1, o_bin=4.
- Backward step: locked at bin 5 (grey 000111), drive grey 000110 (bin 4) -> o_err pulse; o_err_sticky=1; o_err_count=1; re-lock with o_bin=4.
- Clear vs error collision: o_err_count=3, pulse i_err_clr in the same cycle as a new error -> o_err_count=1, o_err_sticky=1. With ERR_W=2, 5 errors give o_err_count=3 (saturated).
- Reset mid-stream: assert i_reset while TRACK with o_step_count=20 -> next cycle all outputs at reset values and state ACQUIRE.
